// File: rtl/div_stall_unit.sv
// div_stall_unit: iterative restoring DIV/DIVU that stalls E until done.
// Optional macro DIV_ZERO_FAST_EN: zero divisor finishes in one cycle.
module div_stall_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_enE,
  input  logic             div_signedE,
  input  logic [WIDTH-1:0] opaE,
  input  logic [WIDTH-1:0] opbE,
  input  logic             holdE,
  input  logic             cancel,
  output logic             div_stallE,
  output logic             div_validE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_negq;
  logic             r_negr;
  logic             r_zero;

  logic             w_nega;
  logic             w_negb;
  logic [WIDTH-1:0] w_absa;
  logic [WIDTH-1:0] w_absb;
  logic             w_bzero;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_fin_hi;
  logic [WIDTH-1:0] w_fin_lo;

  always_comb begin
    w_nega  = div_signedE & opaE[WIDTH-1];
    w_negb  = div_signedE & opbE[WIDTH-1];
    w_absa  = w_nega ? -opaE : opaE;
    w_absb  = w_negb ? -opbE : opbE;
    w_bzero = (opbE == '0);
  end

  // Dividend register doubles as the quotient shift register.
  always_comb begin
    w_shift   = {r_rem, r_dvd[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_dvs});
    w_rem_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_dvs)
                     : w_shift[WIDTH-1:0];
    w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};
    if (r_zero) begin
      w_fin_hi = r_opa;
      w_fin_lo = '1;
    end else begin
      w_fin_hi = r_negr ? -w_rem_nxt : w_rem_nxt;
      w_fin_lo = r_negq ? -w_quo_nxt : w_quo_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_opa   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_zero  <= 1'b0;
    end else if (cancel) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (div_enE) begin
            r_dvd  <= w_absa;
            r_dvs  <= w_absb;
            r_rem  <= '0;
            r_opa  <= opaE;
            r_negq <= w_nega ^ w_negb;
            r_negr <= w_nega;
            r_zero <= w_bzero;
            r_cnt  <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (w_bzero) begin
              r_hi    <= opaE;
              r_lo    <= '1;
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
            end
`else
            r_state <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (!div_enE) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_hi    <= w_fin_hi;
              r_lo    <= w_fin_lo;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (!holdE) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign div_stallE = div_enE & (r_state != DONE) & ~cancel;
  assign div_validE = (r_state == DONE);
  assign hiE        = r_hi;
  assign loE        = r_lo;

endmodule

// File: tb/tb_div_stall_unit.sv
// tb_div_stall_unit: directed + random divides against a queued model.
// Stall lengths, results, hold, cancel, kill and reset are checked.
module tb_div_stall_unit;

  logic        clk;
  logic        resetn;
  logic        div_enE;
  logic        div_signedE;
  logic [31:0] opaE;
  logic [31:0] opbE;
  logic        holdE;
  logic        cancel;
  logic        div_stallE;
  logic        div_validE;
  logic [31:0] hiE;
  logic [31:0] loE;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sb_q[$];

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLEN = 1;
`else
  localparam int ZLEN = 33;
`endif

  div_stall_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_enE    (div_enE),
    .div_signedE(div_signedE),
    .opaE       (opaE),
    .opbE       (opbE),
    .holdE      (holdE),
    .cancel     (cancel),
    .div_stallE (div_stallE),
    .div_validE (div_validE),
    .hiE        (hiE),
    .loE        (loE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit s,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'd0;
    end else if (s) begin
      e.lo = sa / sb;
      e.hi = sa % sb;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  task automatic drive(input bit s,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] elo,
                       input logic [31:0] ehi);
    exp_t e;
    e.lo = elo;
    e.hi = ehi;
    sb_q.push_back(e);
    div_signedE = s;
    opaE        = a;
    opbE        = b;
    div_enE     = 1'b1;
    holdE       = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int exp_len);
    int n;
    exp_t e;
    n = 0;
    while (div_stallE && n < 100) begin
      n++;
      if (n == 5) begin
        opaE = $urandom;
        opbE = $urandom;
      end
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall_len"}, 32'(n), 32'(exp_len));
    chk({tag, "_valid"}, 32'(div_validE), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_lo"}, loE, e.lo);
      chk({tag, "_hi"}, hiE, e.hi);
    end
  endtask

  task automatic release_idle(input string tag);
    holdE   = 1'b0;
    div_enE = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_idle_valid"}, 32'(div_validE), 32'd0);
  endtask

  task automatic run(input string tag,
                     input bit s,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] elo,
                     input logic [31:0] ehi,
                     input int len);
    drive(s, a, b, elo, ehi);
    #1;
    wait_done(tag, len);
    release_idle(tag);
  endtask

  initial begin
    logic [31:0] lo_s;
    logic [31:0] hi_s;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t m;

    resetn      = 1'b0;
    div_enE     = 1'b0;
    div_signedE = 1'b0;
    opaE        = '0;
    opbE        = '0;
    holdE       = 1'b0;
    cancel      = 1'b0;
    #1;
    chk("rst_stall", 32'(div_stallE), 32'd0);
    chk("rst_valid", 32'(div_validE), 32'd0);
    chk("rst_hi", hiE, 32'd0);
    chk("rst_lo", loE, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // DIVU 100/7, then 4 extra hold cycles, then back-to-back DIV 9/3
    drive(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    #1;
    wait_done("divu_100_7", 33);
    lo_s = loE;
    hi_s = hiE;
    for (int i = 0; i < 4; i++) begin
      opaE = $urandom;
      opbE = $urandom;
      @(negedge clk);
      #1;
      chk("hold_valid", 32'(div_validE), 32'd1);
      chk("hold_stall", 32'(div_stallE), 32'd0);
      chk("hold_lo", loE, lo_s);
      chk("hold_hi", hiE, hi_s);
    end
    drive(1'b1, 32'd9, 32'd3, 32'd3, 32'd0);
    holdE = 1'b0;
    @(negedge clk);
    #1;
    holdE = 1'b1;
    chk("b2b_idle_valid", 32'(div_validE), 32'd0);
    wait_done("div_9_3", 33);
    release_idle("div_9_3");

    run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 32'd0, 33);
    run("divu_5_0", 1'b0, 32'd5, 32'd0,
        32'hFFFF_FFFF, 32'd5, ZLEN);
    run("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0,
        32'hFFFF_FFFF, 32'hFFFF_FFFB, ZLEN);
    run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
        32'hFFFF_FFFD, 32'd1, 33);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = 32'($urandom_range(1, 5000));
      if (i >= 3 && ra[0]) rb = -rb;
      m = model(i >= 3, ra, rb);
      run("rand", i >= 3, ra, rb, m.lo, m.hi, 33);
    end

    // div_enE dropped mid-BUSY: must restart with a full stall
    div_signedE = 1'b0;
    opaE        = 32'd1234;
    opbE        = 32'd5;
    div_enE     = 1'b1;
    holdE       = 1'b1;
    repeat (7) @(negedge clk);
    div_enE = 1'b0;
    @(negedge clk);
    drive(1'b0, 32'd77, 32'd8, 32'd9, 32'd5);
    #1;
    wait_done("kill_restart", 33);
    release_idle("kill_restart");

    // cancel at BUSY cycle 10
    div_signedE = 1'b0;
    opaE        = 32'd999;
    opbE        = 32'd4;
    div_enE     = 1'b1;
    holdE       = 1'b1;
    #1;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1;
    chk("cancel_stall", 32'(div_stallE), 32'd0);
    chk("cancel_valid", 32'(div_validE), 32'd0);
    @(negedge clk);
    cancel = 1'b0;
    drive(1'b0, 32'd50, 32'd6, 32'd8, 32'd2);
    #1;
    chk("cancel_idle_valid", 32'(div_validE), 32'd0);
    wait_done("cancel_restart", 33);
    release_idle("cancel_restart");

    // asynchronous reset mid-BUSY
    div_signedE = 1'b0;
    opaE        = 32'd4321;
    opbE        = 32'd3;
    div_enE     = 1'b1;
    holdE       = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    resetn  = 1'b0;
    div_enE = 1'b0;
    #1;
    chk("midrst_hi", hiE, 32'd0);
    chk("midrst_lo", loE, 32'd0);
    chk("midrst_valid", 32'(div_validE), 32'd0);
    chk("midrst_stall", 32'(div_stallE), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run("post_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
